feature_vector_packer: RTL and testbench
========================================

Name: feature_vector_packer

Overview:
- Producer side of the feature-vector interface consumed by the dot-product/requantize stage.
- Accepts a serial stream of unsigned PRECISION-bit quantized features, one per handshake.
- Removes the input zero point and assembles INPUT_DIM signed (PRECISION+1)-bit elements into a vector.
- Presents the vector on a valid/ready port for the multiplier array; sits between the feature FIFO/memory reader and the feature extractor layer.

Parameters:
- INPUT_DIM, 4, number of vector elements; must be ≥ 1.
- PRECISION, 8, width of the unsigned input feature.
- INPUT_ZERO_POINT, 0, unsigned zero point subtracted from each feature; range 0..2^PRECISION-1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input feature valid
- in_ready  out  1  packer can accept a feature
- in_feature  in  PRECISION  unsigned quantized feature
- in_last  in  1  final feature of the current vector (early close)
- out_valid  out  1  feature_matrix holds a complete vector
- out_ready  in  1  consumer accepts the vector
- feature_matrix  out  signed [PRECISION:0] x INPUT_DIM  dequantized vector, element 0 = first received
- out_padded  out  1  vector was closed early by in_last and zero-padded

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high, port name reset.
- Reset values: in_ready=1, out_valid=0, out_padded=0, all feature_matrix elements=0, fill counter=0, state=FILL.
- Element arithmetic: elem = signed({1'b0,in_feature}) - signed({1'b0,INPUT_ZERO_POINT}), PRECISION+1 bits. Range -(2^PRECISION-1)..(2^PRECISION-1); never overflows, so no saturation.
- FSM states: FILL, PRESENT.
- FILL:
  - in_ready=1.
  - On in_valid&in_ready, write elem into slot idx and increment idx.
  - Transition to PRESENT when idx==INPUT_DIM-1 or in_last=1, on the same edge as the write.
  - Early close: slots idx+1..INPUT_DIM-1 are written to 0 and out_padded=1.
  - Full close: out_padded=0.
  - in_last on slot INPUT_DIM-1 counts as a full close (out_padded=0).
- PRESENT:
  - out_valid=1, in_ready=0 (single-buffer build).
  - feature_matrix and out_padded stay stable until out_valid&out_ready.
  - On that handshake: out_valid=0, idx=0, return to FILL.
- Latency: out_valid rises on the edge after the last accepted feature. Single-buffer throughput is one vector per INPUT_DIM+1 cycles with out_ready held high.
- Element clearing: slots are not cleared on handoff, only overwritten or padded. Stale data must never be visible while out_valid=1.
- out_ready while out_valid=0 is ignored.
- Reset mid-vector: partial vector discarded, all state returns to reset values.
- in_valid while in_ready=0: no effect; the producer holds the data.

Optional Feature:
- Macro PACKER_DOUBLE_BUFFER_EN.
- Defined:
  - Two vector buffers (ping/pong). Filling continues into the free buffer while the other is presented.
  - in_ready=0 only when both buffers are full.
  - Presentation order equals fill order; out_padded is tracked per buffer.
  - Sustained throughput is one vector per INPUT_DIM cycles.
  - Simultaneous output handshake and fill-complete in the same cycle: the freed buffer becomes fillable next cycle, and the completed buffer is presented next cycle with no bubble.
- Undefined: single buffer exactly as in Behaviour.

Decomposition:
- Package feature_packer_pkg:
  - typedef packer_state_t enum {FILL, PRESENT}.
  - Function dequant(feature, zp) returning logic signed [PRECISION:0].
  - localparam IDX_W = $clog2(INPUT_DIM) (minimum 1).
- Sub-module vector_buffer (fill index, slot write, pad logic, padded flag).
  - Instantiated once in the single-buffer build, twice under PACKER_DOUBLE_BUFFER_EN.
  - Top level keeps the FSM and ping/pong pointers.

Test Plan:
- Basic fill (INPUT_ZERO_POINT=128): features 128,255,0,130 with out_ready=1 → feature_matrix={0,127,-128,2}, out_padded=0, out_valid high exactly 1 cycle after the 4th accept.
- Early close: features 10,20 with in_last on 20, INPUT_ZERO_POINT=0 → {10,20,0,0}, out_padded=1, next vector starts at slot 0.
- Backpressure: out_ready=0 for 5 cycles after fill → out_valid and feature_matrix stable, in_ready=0 (single) or accepts exactly INPUT_DIM more features then stalls (double).
- Mid-vector reset: 2 features accepted, reset pulsed asynchronously between edges → out_valid=0, in_ready=1 immediately; the next 4 features form a clean vector.
- Back-to-back streaming, 8 vectors with in_valid and out_ready always high → single buffer: 1 idle in_ready cycle per vector; double buffer: zero idle cycles; order and values match a reference queue.
- Extremes with INPUT_ZERO_POINT=255: input 0 → -255; input 255 → 0; no wrap.

Source files
------------

// File: rtl/feature_packer_pkg.sv
// -----------------------------------------------------------------------------
// feature_packer_pkg
//
// Shared types and helpers for the feature-vector packer.
//   packer_state_t : FILL / PRESENT state encoding of the packer FSM.
//   MAX_PRECISION  : widest feature the dequant helper supports.
//   idx_width()    : fill-index width, never less than one bit.
//   dequant()      : feature - zero_point as a signed value one bit wider than
//                    the operands. Callers keep the low PRECISION+1 bits.
// -----------------------------------------------------------------------------
package feature_packer_pkg;

    typedef enum logic [0:0] {
        FILL    = 1'b0,
        PRESENT = 1'b1
    } packer_state_t;

    localparam int MAX_PRECISION = 31;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Both operands are unsigned and below 2^PRECISION, so the difference
    // always fits in PRECISION+1 signed bits. No saturation is needed.
    function automatic logic signed [MAX_PRECISION:0] dequant(
        input logic [MAX_PRECISION-1:0] feature,
        input logic [MAX_PRECISION-1:0] zp
    );
        return $signed({1'b0, feature}) - $signed({1'b0, zp});
    endfunction

endpackage

// File: rtl/feature_vector_packer_buffer.sv
// -----------------------------------------------------------------------------
// vector_buffer
//
// One vector's worth of storage. It holds the fill index, writes incoming
// elements into their slots, zero-pads the tail on an early close, and keeps a
// padded flag.
//
// The index returns to zero on the closing write. The buffer is never written
// while it is being presented, so this has the same effect as clearing the
// index on the output handoff.
//
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (all state to zero)
//   wr_en_i     : accept wr_elem_i into the current slot this cycle
//   wr_elem_i   : dequantized element, PRECISION+1 bits, two's complement
//   wr_last_i   : the accepted element closes the vector early
//   close_o     : this cycle's write completes the vector (full or early)
//   elems_o     : slot j at bits [j*(PRECISION+1) +: PRECISION+1]
//   padded_o    : the last completed vector was closed early and zero-padded
// -----------------------------------------------------------------------------
module vector_buffer
    import feature_packer_pkg::*;
#(
    parameter int INPUT_DIM = 4,
    parameter int PRECISION = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 wr_en_i,
    input  logic [PRECISION:0]                   wr_elem_i,
    input  logic                                 wr_last_i,
    output logic                                 close_o,
    output logic [INPUT_DIM*(PRECISION+1)-1:0]   elems_o,
    output logic                                 padded_o
);

    localparam int EW    = PRECISION + 1;
    localparam int IDX_W = idx_width(INPUT_DIM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_DIM - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [EW-1:0]    slot_q [INPUT_DIM];
    logic [EW-1:0]    slot_d [INPUT_DIM];
    logic             padded_q, padded_d;
    logic             at_end;

    assign at_end  = (idx_q == LAST_IDX);
    // in_last on the final slot is still a full close. at_end decides padding.
    assign close_o = wr_en_i && (at_end || wr_last_i);

    always_comb begin
        idx_d    = idx_q;
        padded_d = padded_q;
        for (int j = 0; j < INPUT_DIM; j++) begin
            slot_d[j] = slot_q[j];
            if (wr_en_i) begin
                if (IDX_W'(j) == idx_q) begin
                    slot_d[j] = wr_elem_i;
                end else if (close_o && (IDX_W'(j) > idx_q)) begin
                    // Early close: clear the tail so no stale data is visible.
                    slot_d[j] = '0;
                end
            end
        end
        if (wr_en_i) begin
            idx_d = close_o ? '0 : idx_q + IDX_W'(1);
        end
        if (close_o) begin
            padded_d = !at_end;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q    <= '0;
            padded_q <= 1'b0;
            for (int j = 0; j < INPUT_DIM; j++) begin
                slot_q[j] <= '0;
            end
        end else begin
            idx_q    <= idx_d;
            padded_q <= padded_d;
            for (int j = 0; j < INPUT_DIM; j++) begin
                slot_q[j] <= slot_d[j];
            end
        end
    end

    for (genvar g = 0; g < INPUT_DIM; g++) begin : g_flat
        assign elems_o[g*EW +: EW] = slot_q[g];
    end

    assign padded_o = padded_q;

endmodule

// File: rtl/feature_vector_packer.sv
// -----------------------------------------------------------------------------
// feature_vector_packer
//
// This block packs serial quantized features into signed vectors for the
// dot-product stage. Each accepted feature has the input zero point removed
// and is written into the next vector slot. When the last slot is filled, or
// in_last is seen, the vector is closed and presented on a valid/ready port.
//
// Handshakes: a transfer occurs on a rising clk edge where valid and ready
// are both high. Valid is never withdrawn before that transfer, and the data
// stays stable while valid is high. Ready may depend only on registered state.
//
// Build option: define PACKER_DOUBLE_BUFFER_EN to use two ping/pong buffers.
// With this option, filling continues while the other buffer is presented.
// Without it, one buffer alternates between FILL and PRESENT.
//
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   in_valid        : input feature valid
//   in_ready        : packer can accept a feature
//   in_feature      : unsigned PRECISION-bit feature
//   in_last         : feature closes the current vector early
//   out_valid       : feature_matrix holds a complete vector
//   out_ready       : consumer accepts the vector
//   feature_matrix  : element j at bits [j*(PRECISION+1) +: PRECISION+1],
//                     element 0 is the first received
//   out_padded      : vector was closed early and zero-padded
//   dbg_state_o     : FSM state view (0 = FILL, 1 = PRESENT)
// -----------------------------------------------------------------------------
module feature_vector_packer
    import feature_packer_pkg::*;
#(
    parameter int INPUT_DIM        = 4,
    parameter int PRECISION        = 8,
    parameter int INPUT_ZERO_POINT = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [PRECISION-1:0]                 in_feature,
    input  logic                                 in_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [INPUT_DIM*(PRECISION+1)-1:0]   feature_matrix,
    output logic                                 out_padded,
    output logic                                 dbg_state_o
);

    localparam int MW = INPUT_DIM * (PRECISION + 1);
    localparam logic [MAX_PRECISION-1:0] ZP_EXT = MAX_PRECISION'(INPUT_ZERO_POINT);

    // Dequantize at full helper width. The upper bits are only sign extension.
    logic signed [MAX_PRECISION:0] deq_full;
    logic [PRECISION:0]            in_elem;
    logic                          unused_deq_hi;

    assign deq_full      = dequant(MAX_PRECISION'(in_feature), ZP_EXT);
    assign in_elem       = deq_full[PRECISION:0];
    assign unused_deq_hi = ^deq_full[MAX_PRECISION:PRECISION+1];

`ifdef PACKER_DOUBLE_BUFFER_EN

    // Ping/pong pointers: fill_ptr is the buffer being filled, out_ptr is the
    // buffer being presented. full_q marks buffers that hold a closed vector.
    // Buffers close in fill order and are presented in the same order.
    logic [1:0]    full_q, full_d;
    logic          fill_ptr_q, fill_ptr_d;
    logic          out_ptr_q, out_ptr_d;
    logic [1:0]    buf_wr;
    logic [1:0]    buf_close;
    logic [1:0]    buf_padded;
    logic [MW-1:0] buf_elems [2];
    logic          fill_done;
    packer_state_t state_view;

    for (genvar b = 0; b < 2; b++) begin : g_buf
        vector_buffer #(
            .INPUT_DIM (INPUT_DIM),
            .PRECISION (PRECISION)
        ) u_buf (
            .clk       (clk),
            .reset     (reset),
            .wr_en_i   (buf_wr[b]),
            .wr_elem_i (in_elem),
            .wr_last_i (in_last),
            .close_o   (buf_close[b]),
            .elems_o   (buf_elems[b]),
            .padded_o  (buf_padded[b])
        );
    end

    // Only the buffer being filled can be written, so at most one close bit
    // is ever set.
    assign fill_done = |buf_close;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q     <= 2'b00;
            fill_ptr_q <= 1'b0;
            out_ptr_q  <= 1'b0;
        end else begin
            full_q     <= full_d;
            fill_ptr_q <= fill_ptr_d;
            out_ptr_q  <= out_ptr_d;
        end
    end

    // Next state. A handoff and a fill completion in the same cycle touch
    // different buffers. The freed buffer can be filled next cycle, and the
    // newly closed buffer is presented next cycle with no bubble.
    always_comb begin
        full_d     = full_q;
        fill_ptr_d = fill_ptr_q;
        out_ptr_d  = out_ptr_q;
        if (out_valid && out_ready) begin
            full_d[out_ptr_q] = 1'b0;
            out_ptr_d         = ~out_ptr_q;
        end
        if (fill_done) begin
            full_d[fill_ptr_q] = 1'b1;
            fill_ptr_d         = ~fill_ptr_q;
        end
    end

    // Outputs
    always_comb begin
        in_ready             = !full_q[fill_ptr_q];
        out_valid            = full_q[out_ptr_q];
        feature_matrix       = buf_elems[out_ptr_q];
        out_padded           = buf_padded[out_ptr_q];
        buf_wr               = 2'b00;
        buf_wr[fill_ptr_q]   = in_valid && in_ready;
        state_view           = out_valid ? PRESENT : FILL;
        dbg_state_o          = state_view[0];
    end

`else

    packer_state_t state_q, state_d;
    logic          wr_en;
    logic          close;

    assign wr_en = in_valid && in_ready;

    vector_buffer #(
        .INPUT_DIM (INPUT_DIM),
        .PRECISION (PRECISION)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_en),
        .wr_elem_i (in_elem),
        .wr_last_i (in_last),
        .close_o   (close),
        .elems_o   (feature_matrix),
        .padded_o  (out_padded)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (close)     state_d = PRESENT;
            PRESENT: if (out_ready) state_d = FILL;
            default:                state_d = FILL;
        endcase
    end

    // Outputs. The buffer is frozen while the vector is presented.
    always_comb begin
        in_ready    = (state_q == FILL);
        out_valid   = (state_q == PRESENT);
        dbg_state_o = state_q[0];
    end

`endif

endmodule

// File: tb/tb_feature_vector_packer.sv
// -----------------------------------------------------------------------------
// tb_feature_vector_packer
//
// Three packers are driven from one shared input stream. Their zero points are
// 128, 0 and 255. Table vectors carry hand-computed results for every zero
// point. Each completed vector also pushes a model-computed expectation into
// exp_q, and the monitor pops it on every output handshake.
// -----------------------------------------------------------------------------
module tb_feature_vector_packer;

    localparam int DIM = 4;
    localparam int P   = 8;
    localparam int EW  = P + 1;
    localparam int MW  = DIM * EW;
    localparam int QW  = 1 + 3 * MW;
    localparam int NT  = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          in_valid, in_last, out_ready;
    logic [P-1:0]  in_feature;
    logic          in_ready, out_valid, out_padded, dbg_state;
    logic [MW-1:0] feature_matrix;
    logic          in_ready_z0, out_valid_z0, out_padded_z0, dbg_z0;
    logic [MW-1:0] fm_z0;
    logic          in_ready_z255, out_valid_z255, out_padded_z255, dbg_z255;
    logic [MW-1:0] fm_z255;

    feature_vector_packer #(.INPUT_DIM(DIM), .PRECISION(P), .INPUT_ZERO_POINT(128)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_feature(in_feature), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .feature_matrix(feature_matrix),
        .out_padded(out_padded), .dbg_state_o(dbg_state)
    );

    feature_vector_packer #(.INPUT_DIM(DIM), .PRECISION(P), .INPUT_ZERO_POINT(0)) u_dut_zp0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_z0),
        .in_feature(in_feature), .in_last(in_last), .out_valid(out_valid_z0),
        .out_ready(out_ready), .feature_matrix(fm_z0),
        .out_padded(out_padded_z0), .dbg_state_o(dbg_z0)
    );

    feature_vector_packer #(.INPUT_DIM(DIM), .PRECISION(P), .INPUT_ZERO_POINT(255)) u_dut_zp255 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_z255),
        .in_feature(in_feature), .in_last(in_last), .out_valid(out_valid_z255),
        .out_ready(out_ready), .feature_matrix(fm_z255),
        .out_padded(out_padded_z255), .dbg_state_o(dbg_z255)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [QW-1:0] exp_q[$];
    logic [DIM*P-1:0] cur_f;
    int cur_n = 0;
    int stall_cnt = 0;
    int pushed = 0;
    int vec_seen = 0;

    typedef struct {
        logic [DIM*P-1:0] f;
        int               n;
        logic             last;
        logic [MW-1:0]    e128;
        logic [MW-1:0]    e0;
        logic [MW-1:0]    e255;
        logic             pad;
    } vec_t;

    vec_t tab [NT];

    function automatic logic [MW-1:0] pack4(input int e0, input int e1, input int e2, input int e3);
        logic [MW-1:0] v;
        v = '0;
        v[0*EW +: EW] = EW'(e0);
        v[1*EW +: EW] = EW'(e1);
        v[2*EW +: EW] = EW'(e2);
        v[3*EW +: EW] = EW'(e3);
        return v;
    endfunction

    function automatic logic [DIM*P-1:0] packf(input int f0, input int f1, input int f2, input int f3);
        return {P'(f3), P'(f2), P'(f1), P'(f0)};
    endfunction

    // Reference model: received elements minus zero point, tail zero.
    function automatic logic [MW-1:0] model_vec(input int zp, input logic [DIM*P-1:0] f, input int n);
        logic [MW-1:0] v;
        int e;
        v = '0;
        for (int j = 0; j < DIM; j++) begin
            e = (j < n) ? (int'(f[j*P +: P]) - zp) : 0;
            v[j*EW +: EW] = EW'(e);
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic [P-1:0] f, input logic last);
        int guard;
        guard = 0;
        in_valid   = 1'b1;
        in_feature = f;
        in_last    = last;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            stall_cnt++;
            guard++;
            if (guard > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual=in_ready_low required=accept");
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        cur_f[cur_n*P +: P] = f;
        cur_n++;
        if (cur_n == DIM || last) begin
            exp_q.push_back({(cur_n < DIM), model_vec(0, cur_f, cur_n),
                             model_vec(255, cur_f, cur_n), model_vec(128, cur_f, cur_n)});
            pushed++;
            cur_n = 0;
            cur_f = '0;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0 pending", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [QW-1:0] e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_vector actual=%h required=none", feature_matrix);
            end else begin
                e = exp_q.pop_front();
                vec_seen++;
                check("sb_zp128", feature_matrix, e[MW-1:0]);
                check("sb_zp255", fm_z255, e[2*MW-1:MW]);
                check("sb_zp0", fm_z0, e[3*MW-1:2*MW]);
                check("sb_padded", MW'(out_padded), MW'(e[QW-1]));
                check("sb_valid_peers", MW'({out_valid_z0, out_valid_z255}), MW'(2'b11));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    initial begin
        logic [MW-1:0] snap;
        int exp_stalls;

        tab[0] = '{packf(128, 255, 0, 130), 4, 1'b0, pack4(0, 127, -128, 2),
                   pack4(128, 255, 0, 130), pack4(-127, 0, -255, -125), 1'b0};
        tab[1] = '{packf(10, 20, 0, 0), 2, 1'b1, pack4(-118, -108, 0, 0),
                   pack4(10, 20, 0, 0), pack4(-245, -235, 0, 0), 1'b1};
        tab[2] = '{packf(0, 255, 1, 254), 4, 1'b0, pack4(-128, 127, -127, 126),
                   pack4(0, 255, 1, 254), pack4(-255, 0, -254, -1), 1'b0};
        tab[3] = '{packf(7, 0, 0, 0), 1, 1'b1, pack4(-121, 0, 0, 0),
                   pack4(7, 0, 0, 0), pack4(-248, 0, 0, 0), 1'b1};
        tab[4] = '{packf(1, 2, 3, 4), 4, 1'b1, pack4(-127, -126, -125, -124),
                   pack4(1, 2, 3, 4), pack4(-254, -253, -252, -251), 1'b0};
        tab[5] = '{packf(255, 255, 255, 0), 3, 1'b1, pack4(127, 127, 127, 0),
                   pack4(255, 255, 255, 0), pack4(0, 0, 0, 0), 1'b1};

        cur_f      = '0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_feature = '0;
        in_last    = 1'b0;
        out_ready  = 1'b0;

        // Reset state
        #12;
        check("rst_in_ready", MW'(in_ready), MW'(1'b1));
        check("rst_out_valid", MW'(out_valid), MW'(1'b0));
        check("rst_out_padded", MW'(out_padded), MW'(1'b0));
        check("rst_matrix", feature_matrix, '0);
        check("rst_state", MW'(dbg_state), MW'(1'b0));
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;

        // Table-driven vectors
        for (int t = 0; t < NT; t++) begin
            for (int k = 0; k < tab[t].n; k++) begin
                if (k == tab[t].n - 1)
                    check($sformatf("t%0d_pre_valid", t), MW'(out_valid), MW'(1'b0));
                send(tab[t].f[k*P +: P], tab[t].last && (k == tab[t].n - 1));
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            check($sformatf("t%0d_latency_valid", t), MW'(out_valid), MW'(1'b1));
            check($sformatf("t%0d_state", t), MW'(dbg_state), MW'(1'b1));
            check($sformatf("t%0d_zp128", t), feature_matrix, tab[t].e128);
            check($sformatf("t%0d_zp0", t), fm_z0, tab[t].e0);
            check($sformatf("t%0d_zp255", t), fm_z255, tab[t].e255);
            check($sformatf("t%0d_padded", t), MW'(out_padded), MW'(tab[t].pad));
            drain();
        end

        // Backpressure: the presented vector holds still while out_ready is low
        out_ready = 1'b0;
        for (int k = 0; k < DIM; k++) send(P'($urandom_range(0, 255)), 1'b0);
        in_valid = 1'b0;
        snap = feature_matrix;
`ifdef PACKER_DOUBLE_BUFFER_EN
        for (int k = 0; k < DIM; k++) send(P'($urandom_range(0, 255)), 1'b0);
        in_valid   = 1'b1;
        in_feature = 8'hA5;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_in_ready_full", MW'(in_ready), MW'(1'b0));
            check("bp_valid", MW'(out_valid), MW'(1'b1));
            check("bp_matrix", feature_matrix, snap);
        end
`else
        in_valid   = 1'b1;
        in_feature = 8'hA5;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_in_ready", MW'(in_ready), MW'(1'b0));
            check("bp_valid", MW'(out_valid), MW'(1'b1));
            check("bp_matrix", feature_matrix, snap);
            check("bp_padded", MW'(out_padded), MW'(1'b0));
        end
`endif
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Mid-vector reset between edges
        send(8'd50, 1'b0);
        send(8'd60, 1'b0);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("mrst_in_ready", MW'(in_ready), MW'(1'b1));
        check("mrst_out_valid", MW'(out_valid), MW'(1'b0));
        check("mrst_matrix", feature_matrix, '0);
        #1;
        reset = 1'b0;
        cur_n = 0;
        cur_f = '0;
        @(posedge clk);
        #1;
        send(8'd200, 1'b0);
        send(8'd100, 1'b0);
        send(8'd128, 1'b0);
        send(8'd129, 1'b0);
        in_valid = 1'b0;
        check("mrst_clean_vec", feature_matrix, pack4(72, -28, 0, 1));
        check("mrst_clean_pad", MW'(out_padded), MW'(1'b0));
        drain();

        // Back-to-back streaming
        stall_cnt = 0;
        for (int v = 0; v < 8; v++)
            for (int k = 0; k < DIM; k++)
                send(P'($urandom_range(0, 255)), 1'b0);
        in_valid = 1'b0;
`ifdef PACKER_DOUBLE_BUFFER_EN
        exp_stalls = 0;
`else
        exp_stalls = 7;
`endif
        check("stream_stalls", MW'(stall_cnt), MW'(exp_stalls));
        drain();

        check("final_queue_empty", MW'(exp_q.size()), '0);
        check("final_vec_count", MW'(vec_seen), MW'(pushed));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
